// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control unit: sequences each instruction through
// fetch/decode/execute/memory/write-back, with a memory wait handshake,
// a retired-instruction counter and illegal-opcode flagging.
module multicycle_controller #(
  parameter int unsigned CNT_W          = 32,
  parameter bit          WAIT_STATES_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             mem_write,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_op,
  output logic [1:0]       imm_src,
  output logic             illegal_instr,
  output logic [CNT_W-1:0] retired
);

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpRType = 7'b0110011;
  localparam logic [6:0] OpIType = 7'b0010011;
  localparam logic [6:0] OpJal   = 7'b1101111;
  localparam logic [6:0] OpBeq   = 7'b1100011;

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecR,
    StExecI,
    StAluWb,
    StJal,
    StBeq
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] retired_q;
  logic             ready;

  // Raw strobes before reset gating
  logic mem_req_s, ir_write_s, mem_write_s, reg_write_s, illegal_s;
  logic pc_update, branch;

  // With wait states disabled the memory always completes in one cycle
  assign ready = WAIT_STATES_EN ? mem_ready : 1'b1;

  // State sequencing and retired-instruction counting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      retired_q <= '0;
    end else begin
      unique case (state_q)
        StFetch: if (ready) state_q <= StDecode;
        StDecode: begin
          unique case (opcode)
            OpLoad, OpStore: state_q <= StMemAdr;
            OpRType:         state_q <= StExecR;
            OpIType:         state_q <= StExecI;
            OpJal:           state_q <= StJal;
            OpBeq:           state_q <= StBeq;
            default:         state_q <= StFetch;
          endcase
        end
        StMemAdr: state_q <= (opcode == OpStore) ? StMemWrite : StMemRead;
        StMemRead: if (ready) state_q <= StMemWb;
        StMemWrite: begin
          if (ready) begin
            state_q   <= StFetch;
            retired_q <= retired_q + CntOne;
          end
        end
        StMemWb, StAluWb, StBeq: begin
          state_q   <= StFetch;
          retired_q <= retired_q + CntOne;
        end
        StExecR, StExecI, StJal: state_q <= StAluWb;
        default: state_q <= StFetch;
      endcase
    end
  end

  // Moore output decode; strobes needing the handshake are qualified by ready
  always_comb begin
    mem_req_s   = 1'b0;
    adr_src     = 1'b0;
    ir_write_s  = 1'b0;
    pc_update   = 1'b0;
    branch      = 1'b0;
    mem_write_s = 1'b0;
    reg_write_s = 1'b0;
    illegal_s   = 1'b0;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    result_src  = 2'b00;
    alu_op      = 2'b00;
    unique case (state_q)
      StFetch: begin
        mem_req_s  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write_s = ready;
        pc_update  = ready;
      end
      StDecode: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        illegal_s = !(opcode inside {OpLoad, OpStore, OpRType, OpIType, OpJal, OpBeq});
      end
      StMemAdr: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      StMemRead: begin
        mem_req_s = 1'b1;
        adr_src   = 1'b1;
      end
      StMemWb: begin
        result_src  = 2'b01;
        reg_write_s = 1'b1;
      end
      StMemWrite: begin
        mem_req_s   = 1'b1;
        adr_src     = 1'b1;
        mem_write_s = ready;
      end
      StExecR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      StExecI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      StAluWb: reg_write_s = 1'b1;
      StJal: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
      end
      StBeq: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
      end
      default: ;
    endcase
  end

  // Immediate format select straight from the opcode
  always_comb begin
    imm_src = 2'b00;
    unique case (opcode)
      OpStore: imm_src = 2'b01;
      OpBeq:   imm_src = 2'b10;
      OpJal:   imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  // Strobes are held low for the whole time reset is asserted
  assign mem_req       = mem_req_s & rst_n;
  assign ir_write      = ir_write_s & rst_n;
  assign pc_write      = (pc_update | (branch & zero)) & rst_n;
  assign mem_write     = mem_write_s & rst_n;
  assign reg_write     = reg_write_s & rst_n;
  assign illegal_instr = illegal_s & rst_n;
  assign retired       = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: a per-instruction step model queues expected output
// vectors; a negedge monitor pops and compares against the DUT.
module tb_multicycle_controller;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned VW    = 17 + CNT_W;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [6:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             mem_req, adr_src, ir_write, pc_write, mem_write, reg_write;
  logic [1:0]       alu_src_a, alu_src_b, result_src, alu_op, imm_src;
  logic             illegal_instr;
  logic [CNT_W-1:0] retired;

  multicycle_controller #(
    .CNT_W         (CNT_W),
    .WAIT_STATES_EN(1'b1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .zero         (zero),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .adr_src      (adr_src),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .mem_write    (mem_write),
    .reg_write    (reg_write),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .result_src   (result_src),
    .alu_op       (alu_op),
    .imm_src      (imm_src),
    .illegal_instr(illegal_instr),
    .retired      (retired)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, JL = 7'b1101111, BQ = 7'b1100011;

  logic [VW-1:0] exp_q[$];
  int            vectors     = 0;
  int            miscompares = 0;
  int            model_cnt   = 0;

  function automatic logic [1:0] imm_of(input logic [6:0] op);
    case (op)
      ST:      return 2'b01;
      BQ:      return 2'b10;
      JL:      return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic bit is_legal(input logic [6:0] op);
    return (op == LD) || (op == ST) || (op == RT) || (op == IT) || (op == JL) || (op == BQ);
  endfunction

  // One clock of stimulus plus its expected outputs.
  // str = {mem_req, adr_src, ir_write, pc_update, mem_write, reg_write}
  task automatic step(input logic [5:0] str, input logic [1:0] a, input logic [1:0] b,
                      input logic [1:0] rs, input logic [1:0] aop, input logic br,
                      input logic ill, input logic rdy, input bit abort);
    logic          z;
    logic [CNT_W-1:0] cnt;
    z         = 1'($urandom_range(0, 1));
    zero      = z;
    mem_ready = rdy;
    cnt       = model_cnt[CNT_W-1:0];
    exp_q.push_back({str[5:3], str[2] | (br & z), str[1:0], a, b, rs, aop, imm_of(opcode),
                     ill, cnt});
    if (abort) begin
      @(negedge clk);
      #2 rst_n = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  // One cycle with reset held low, then release just after the edge
  task automatic reset_step();
    logic [CNT_W-1:0] cnt;
    model_cnt = 0;
    cnt       = '0;
    zero      = 1'($urandom_range(0, 1));
    mem_ready = 1'($urandom_range(0, 1));
    exp_q.push_back({6'b000000, 2'b00, 2'b10, 2'b10, 2'b00, imm_of(opcode), 1'b0, cnt});
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // Instruction-level model: the cycle list each instruction class must produce
  task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input bit abort);
    opcode = op;
    repeat (fw) step(6'b100000, 2'b00, 2'b10, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(6'b101100, 2'b00, 2'b10, 2'b10, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    step(6'b000000, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0, !is_legal(op), rnd(), 1'b0);
    case (op)
      LD: begin
        step(6'b000000, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, rnd(), 1'b0);
        repeat (mw) step(6'b110000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        step(6'b110000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        step(6'b000001, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, rnd(), 1'b0);
      end
      ST: begin
        step(6'b000000, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, rnd(), 1'b0);
        repeat (mw) step(6'b110000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        step(6'b110010, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
      end
      RT: begin
        step(6'b000000, 2'b10, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, rnd(), 1'b0);
        step(6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, rnd(), 1'b0);
      end
      IT: begin
        step(6'b000000, 2'b10, 2'b01, 2'b00, 2'b10, 1'b0, 1'b0, rnd(), abort);
        if (abort) begin
          reset_step();
          return;
        end
        step(6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, rnd(), 1'b0);
      end
      JL: begin
        step(6'b000100, 2'b01, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, rnd(), 1'b0);
        step(6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, rnd(), 1'b0);
      end
      BQ: step(6'b000000, 2'b10, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0, rnd(), 1'b0);
      default: return;  // illegal: back to fetch, not counted
    endcase
    model_cnt = (model_cnt + 1) % (1 << CNT_W);
  endtask

  // Monitor: compare every queued expectation mid-cycle
  always @(negedge clk) begin
    logic [VW-1:0] act, exp;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      act = {mem_req, adr_src, ir_write, pc_write, mem_write, reg_write, alu_src_a, alu_src_b,
             result_src, alu_op, imm_src, illegal_instr, retired};
      vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("FAIL outputs @%0t op=%b: got %b, expected %b", $time, opcode, act, exp);
      end
    end
  end

  initial begin
    logic [6:0] legal_ops[6];
    logic [6:0] op;
    legal_ops = '{LD, ST, RT, IT, JL, BQ};
    rst_n     = 1'b0;
    opcode    = 7'b0;
    zero      = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1 reset_step();

    run_instr(RT, 0, 0, 1'b0);
    run_instr(LD, 0, 2, 1'b0);
    run_instr(ST, 0, 0, 1'b0);
    run_instr(BQ, 0, 0, 1'b0);
    run_instr(BQ, 1, 0, 1'b0);
    run_instr(7'b1111111, 0, 0, 1'b0);
    run_instr(JL, 0, 0, 1'b0);
    for (int i = 0; i < 18; i++) run_instr(IT, 0, 0, 1'b0);
    run_instr(IT, 0, 0, 1'b1);
    run_instr(ST, 2, 1, 1'b0);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        op = 7'($urandom_range(0, 127));
        while (is_legal(op)) op = 7'($urandom_range(0, 127));
      end else begin
        op = legal_ops[$urandom_range(0, 5)];
      end
      run_instr(op, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0,
                ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0,
                (op == IT) && ($urandom_range(0, 9) == 0));
    end

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
